// File: rtl/bcd_7seg_pkg.sv
// Shared constants for the BCD seven-segment scanner: digit width and
// segment glyphs in {g,f,e,d,c,b,a} order, active-high.
package bcd_7seg_pkg;

   localparam int BCD_W = 4;

   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_7seg_decode.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show a dash.
module bcd_7seg_decode
   import bcd_7seg_pkg::*;
(
   input  logic [BCD_W-1:0] code,
   output logic [6:0]       seg
);

   always_comb begin
      seg = SEG_DASH;
      case (code)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Multiplexed BCD display driver: double-buffered digit data swapped only at
// frame boundaries, leading-zero blanking and a one-cycle ghost guard per slot.
module bcd_7seg_scan
   import bcd_7seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 1000,
   parameter bit COMMON_ANODE = 1'b0
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load,
   output logic                        ready,
   input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]       dp_in,
   input  logic                        blank_lz,
   output logic [6:0]                  seg,
   output logic                        dp,
   output logic [NUM_DIGITS-1:0]       digit_en,
   output logic                        frame_tick
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic POL = COMMON_ANODE;

   logic [CNT_W-1:0]            cnt;
   logic [IDX_W-1:0]            idx;
   logic                        started;
   logic                        pending_valid;
   logic [BCD_W*NUM_DIGITS-1:0] pending_bcd;
   logic [NUM_DIGITS-1:0]       pending_dp;
   logic [BCD_W*NUM_DIGITS-1:0] disp_bcd;
   logic [NUM_DIGITS-1:0]       disp_dp;
   logic [NUM_DIGITS-1:0]       blank_mask;
   logic                        lead;
   logic [BCD_W-1:0]            cur_code;
   logic                        cur_dp;
   logic                        cur_blank;
   logic [6:0]                  glyph;
   logic                        slot_end;
   logic                        wrap;

   assign slot_end = (cnt == CNT_LAST);
   assign wrap     = slot_end && (idx == IDX_LAST);
   // started keeps ready low through reset and for no longer than that.
   assign ready    = started && !pending_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= wrap ? '0 : idx + IDX_W'(1);
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         started       <= 1'b0;
         pending_valid <= 1'b0;
         pending_bcd   <= '0;
         pending_dp    <= '0;
         disp_bcd      <= '0;
         disp_dp       <= '0;
         frame_tick    <= 1'b0;
      end else begin
         started    <= 1'b1;
         frame_tick <= wrap;
         if (wrap && pending_valid) begin
            disp_bcd      <= pending_bcd;
            disp_dp       <= pending_dp;
            pending_valid <= 1'b0;
         end else if (load && ready) begin
            pending_bcd   <= bcd_in;
            pending_dp    <= dp_in;
            pending_valid <= 1'b1;
         end
      end
   end

   // A digit is blanked when it and every more significant digit are zero.
   always_comb begin
      blank_mask = '0;
      lead       = blank_lz;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         lead          = lead && (disp_bcd[i*BCD_W +: BCD_W] == '0);
         blank_mask[i] = lead;
      end
   end

   always_comb begin
      cur_code  = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_code  = disp_bcd[i*BCD_W +: BCD_W];
            cur_dp    = disp_dp[i];
            cur_blank = blank_mask[i];
         end
      end
   end

   bcd_7seg_decode u_decode (
      .code (cur_code),
      .seg  (glyph)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg      <= {7{POL}};
         dp       <= POL;
         digit_en <= {NUM_DIGITS{POL}};
      end else begin
         seg      <= (cur_blank ? SEG_OFF : glyph) ^ {7{POL}};
         dp       <= cur_dp ^ POL;
         digit_en <= ((cnt == '0) ? '0 : (NUM_DIGITS'(1) << idx)) ^ {NUM_DIGITS{POL}};
      end
   end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Randomized bench for bcd_7seg_scan against a frame-position reference model.
module tb_bcd_7seg_scan;

   localparam int N     = 4;
   localparam int SCAN  = 4;
   localparam int FRAME = N * SCAN;

   logic          clk;
   logic          rst;
   logic          load;
   logic          ready;
   logic [15:0]   bcd_in;
   logic [3:0]    dp_in;
   logic          blank_lz;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    digit_en;
   logic          frame_tick;

   int num_compared   = 0;
   int num_mismatched = 0;

   logic [6:0]  glyph_tbl [0:15];
   int          pos;
   logic [15:0] m_disp, m_pend;
   logic [3:0]  m_disp_dp, m_pend_dp;
   bit          m_pendv, m_started;

   bcd_7seg_scan #(
      .NUM_DIGITS   (N),
      .SCAN_DIV     (SCAN),
      .COMMON_ANODE (1'b0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .ready      (ready),
      .bcd_in     (bcd_in),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .dp         (dp),
      .digit_en   (digit_en),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_compared++;
      if (observed !== expected) begin
         num_mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock edge: predict the registered outputs from the pre-edge view,
   // advance the model, then compare just after the edge.
   task automatic tickCycle(output bit accepted);
      int         digit, slot;
      logic [3:0] code;
      logic [6:0] exp_seg;
      logic [3:0] exp_en;
      logic       exp_dp;
      bit         boundary;
      @(posedge clk);
      digit   = pos / SCAN;
      slot    = pos % SCAN;
      code    = m_disp[4*digit +: 4];
      exp_seg = glyph_tbl[code];
      if (blank_lz && digit != 0 && (m_disp >> (4*digit)) == 16'h0)
         exp_seg = 7'b0;
      exp_en   = (slot == 0) ? 4'b0 : 4'(1 << digit);
      exp_dp   = m_disp_dp[digit];
      boundary = (pos == FRAME - 1);
      accepted = load && m_started && !m_pendv;
      if (boundary && m_pendv) begin
         m_disp    = m_pend;
         m_disp_dp = m_pend_dp;
         m_pendv   = 1'b0;
      end else if (accepted) begin
         m_pend    = bcd_in;
         m_pend_dp = dp_in;
         m_pendv   = 1'b1;
      end
      m_started = 1'b1;
      pos       = (pos + 1) % FRAME;
      #1;
      checkOutput("seg", 32'(seg), 32'(exp_seg));
      checkOutput("dp", 32'(dp), 32'(exp_dp));
      checkOutput("digit_en", 32'(digit_en), 32'(exp_en));
      checkOutput("frame_tick", 32'(frame_tick), 32'(boundary));
      checkOutput("ready", 32'(ready), 32'(m_started && !m_pendv));
   endtask

   task automatic runCycles(input int n);
      bit acc;
      for (int i = 0; i < n; i++) tickCycle(acc);
   endtask

   task automatic applyReset();
      rst = 1'b1;
      #1;
      checkOutput("rst_seg", 32'(seg), 32'h0);
      checkOutput("rst_dp", 32'(dp), 32'h0);
      checkOutput("rst_digit_en", 32'(digit_en), 32'h0);
      checkOutput("rst_ready", 32'(ready), 32'h0);
      checkOutput("rst_frame_tick", 32'(frame_tick), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rst_hold_ready", 32'(ready), 32'h0);
      checkOutput("rst_hold_digit_en", 32'(digit_en), 32'h0);
      #2;
      rst       = 1'b0;
      pos       = 0;
      m_disp    = '0;
      m_disp_dp = '0;
      m_pend    = '0;
      m_pend_dp = '0;
      m_pendv   = 1'b0;
      m_started = 1'b0;
   endtask

   // Holds load until the handshake completes, then scrambles the data bus.
   task automatic applyStimulus(input logic [15:0] bcd, input logic [3:0] dpv, input logic blz);
      bit acc = 1'b0;
      bcd_in   = bcd;
      dp_in    = dpv;
      blank_lz = blz;
      load     = 1'b1;
      for (int k = 0; k < 200 && !acc; k++) tickCycle(acc);
      if (!acc) checkOutput("load_accept", 32'h0, 32'h1);
      load   = 1'b0;
      bcd_in = 16'($urandom);
      dp_in  = 4'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] mask;
      glyph_tbl[0]  = 7'b0111111;
      glyph_tbl[1]  = 7'b0000110;
      glyph_tbl[2]  = 7'b1011011;
      glyph_tbl[3]  = 7'b1001111;
      glyph_tbl[4]  = 7'b1100110;
      glyph_tbl[5]  = 7'b1101101;
      glyph_tbl[6]  = 7'b1111101;
      glyph_tbl[7]  = 7'b0000111;
      glyph_tbl[8]  = 7'b1111111;
      glyph_tbl[9]  = 7'b1101111;
      for (int i = 10; i < 16; i++) glyph_tbl[i] = 7'b1000000;

      rst      = 1'b0;
      load     = 1'b0;
      bcd_in   = '0;
      dp_in    = '0;
      blank_lz = 1'b0;
      #2;
      applyReset();
      runCycles(3);

      $display("[TB] digit 9 without blanking");
      applyStimulus(16'h0009, 4'b0000, 1'b0);
      runCycles(2 * FRAME + 8);

      $display("[TB] digit 9 with blanking and dp on digit 3");
      applyStimulus(16'h0009, 4'b1000, 1'b1);
      runCycles(2 * FRAME + 8);

      $display("[TB] back-to-back loads");
      blank_lz = 1'b0;
      applyStimulus(16'h1234, 4'b0000, 1'b0);
      applyStimulus(16'h5678, 4'b0001, 1'b0);
      runCycles(2 * FRAME + 8);

      $display("[TB] dash code");
      applyStimulus(16'h00F0, 4'b0000, 1'b0);
      runCycles(2 * FRAME + 8);

      $display("[TB] reset with pending data");
      applyStimulus(16'h4321, 4'b0101, 1'b0);
      runCycles(5);
      applyReset();
      runCycles(FRAME + 6);

      $display("[TB] randomized loads");
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0:       mask = 16'hFFFF;
            1:       mask = 16'h0FFF;
            2:       mask = 16'h00FF;
            3:       mask = 16'h000F;
            default: mask = 16'h0000;
         endcase
         applyStimulus(16'($urandom) & mask, 4'($urandom), 1'($urandom));
         runCycles($urandom_range(0, 20));
         blank_lz = 1'($urandom);
         runCycles($urandom_range(0, 20));
      end
      runCycles(2 * FRAME);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule

// File: doc/bcd_7seg_scan.md
BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning number of multiplexed BCD digits (1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles per digit slot (>=2).
REQ-003 SHALL have parameter COMMON_ANODE, default 0, meaning 1 inverts seg, dp and digit_en to active-low.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port load  input  1  request to accept bcd_in/dp_in (valid).
REQ-007 SHALL have port ready  output  1  high when a load is accepted this cycle.
REQ-008 SHALL have port bcd_in  input  4*NUM_DIGITS  packed digits, digit 0 (least significant) in bits [3:0].
REQ-009 SHALL have port dp_in  input  NUM_DIGITS  decimal point per digit.
REQ-010 SHALL have port blank_lz  input  1  leading-zero blanking enable, sampled live.
REQ-011 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-012 SHALL have port dp  output  1  decimal point of the active digit, registered.
REQ-013 SHALL have port digit_en  output  NUM_DIGITS  one-hot digit select, registered.
REQ-014 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; digit index SHALL advance at prescaler terminal count, wrapping NUM_DIGITS-1 -> 0.
REQ-016 Frame boundary SHALL be the cycle the digit index wraps to 0; frame_tick SHALL pulse that cycle.
REQ-017 Handshake: transfer when load && ready; data SHALL go to a pending register, setting pending_valid; ready SHALL equal !pending_valid.
REQ-018 At a frame boundary with pending_valid=1, display register SHALL take pending data and pending_valid SHALL clear (ready high next cycle); no mid-frame tearing.
REQ-019 Load coincident with frame boundary while pending_valid=0 SHALL be stored pending and applied at the following boundary.
REQ-020 Load while ready=0 SHALL be ignored with no state change.
REQ-021 Decode: 0-9 SHALL map to standard glyphs (e.g. 9 -> 1101111, 0 -> 0111111, 1 -> 0000110); codes 10-15 SHALL show dash 1000000.
REQ-022 When blank_lz=1, zero digits from most significant downward until the first nonzero SHALL show seg all off; digit 0 SHALL never be blanked; dp SHALL still follow dp_in.
REQ-023 Ghost guard: for the first cycle of each digit slot digit_en SHALL be all inactive; remaining SCAN_DIV-1 cycles SHALL assert the active digit.
REQ-024 Outputs SHALL lag internal digit index by exactly one clk (single output register stage).
REQ-025 COMMON_ANODE=1 SHALL invert seg, dp and digit_en at the output register, including reset values.

Reset
REQ-026 On rst: prescaler, digit index, display and pending registers SHALL clear to 0; pending_valid=0; frame_tick=0.
REQ-027 During rst: seg, dp, digit_en SHALL be at inactive level (0, or 1 if COMMON_ANODE); ready SHALL be 0, rising to 1 the first cycle after rst deasserts.
REQ-028 Reset asserted mid-frame SHALL discard pending data immediately; scan restarts at digit 0, prescaler 0.

Structure
REQ-029 Package bcd_7seg_pkg SHALL hold the segment glyph constants, dash constant and the width constant for one BCD digit.
REQ-030 Combinational sub-module bcd_7seg_decode (4-bit code in, 7-bit seg out) SHALL be instantiated once on the selected digit.
REQ-031 Implementation SHALL contain no latches and no combinational path from load to ready.

Verification (NUM_DIGITS=4, SCAN_DIV=4, COMMON_ANODE=0)
REQ-032 Reset then load bcd_in=16'h0009, blank_lz=0 -> after next frame_tick, digit 0 slot seg=1101111, digits 1-3 seg=0111111.
REQ-033 Same data with blank_lz=1 -> digits 1-3 seg=0000000, digit 0 seg=1101111; digit 3 with dp_in=4'b1000 shows dp=1.
REQ-034 Load 16'h1234 then load 16'h5678 before boundary -> second load ignored (ready=0), display 1234; 5678 accepted after ready returns.
REQ-035 Load 16'h00F0 -> digit 1 seg=1000000 (dash), others per REQ-021.
REQ-036 Check every slot: digit_en=0000 first cycle, one-hot next 3 cycles; frame_tick every 16 cycles.
REQ-037 Assert rst mid-frame with pending_valid=1 -> outputs inactive immediately; after release display shows 0 and ready=1 after one cycle.
